// File: rtl/gcd_sched.sv
//------------------------------------------------------------------------------
// Module   : gcd_sched
// Brief    : Round-robin scheduler sharing one iterative GCD engine among NREQ
//            requesters. Optional engine watchdog: define GCD_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gcd_sched #(
  parameter int W       = 5,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_err,
  output logic              eng_start,
  output logic [W-1:0]      eng_a,
  output logic [W-1:0]      eng_b,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [IDW-1:0] c_ptr_init = IDW'(NREQ - 1);

  if ((NREQ < 2) || (NREQ > 8) || ((2 ** IDW) < NREQ) || (TIMEOUT < 1)) begin : g_bad_params
    $error("gcd_sched: illegal NREQ/IDW/TIMEOUT combination");
  end

  state_t            r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_win;
  logic [NREQ-1:0]   r_gnt;
  logic              r_valid;
  logic [W-1:0]      r_result;
  logic              r_start;
  logic [W-1:0]      r_eng_a;
  logic [W-1:0]      r_eng_b;
  logic              r_busy;

  logic [IDW-1:0]    w_win;
  logic              w_any;
  logic [NREQ-1:0]   w_onehot;
  logic [W-1:0]      w_a;
  logic [W-1:0]      w_b;

  // Rotating priority: indices above the last winner first, then wrap to 0..ptr.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!w_any && req[j] && (IDW'(j) > r_ptr)) begin
        w_any = 1'b1;
        w_win = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!w_any && req[j] && (IDW'(j) <= r_ptr)) begin
        w_any = 1'b1;
        w_win = IDW'(j);
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_a      = '0;
    w_b      = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_onehot[j] = (IDW'(j) == w_win);
      if (IDW'(j) == r_win) begin
        w_a = a_in[j*W +: W];
        w_b = b_in[j*W +: W];
      end
    end
  end

`ifdef GCD_TIMEOUT_EN
  localparam int             c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_err;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= c_ptr_init;
      r_win    <= '0;
      r_gnt    <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_start  <= 1'b0;
      r_eng_a  <= '0;
      r_eng_b  <= '0;
      r_busy   <= 1'b0;
`ifdef GCD_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win   <= w_win;
            r_gnt   <= w_onehot;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        // Operands are sampled at the end of the gnt cycle.
        S_GRANT: begin
          r_gnt <= '0;
          r_ptr <= r_win;
`ifdef GCD_TIMEOUT_EN
          r_err <= 1'b0;
`endif
          if ((w_a == '0) || (w_b == '0)) begin
            r_result <= w_a | w_b;
            r_valid  <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_eng_a <= w_a;
            r_eng_b <= w_b;
            r_start <= 1'b1;
`ifdef GCD_TIMEOUT_EN
            r_cnt   <= '0;
`endif
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_start <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            r_result <= eng_result;
            r_valid  <= 1'b1;
            r_state  <= S_RESP;
          end
`ifdef GCD_TIMEOUT_EN
          else if (r_cnt == c_tmo_last) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_valid  <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign rsp_valid  = r_valid;
  assign rsp_id     = r_win;
  assign rsp_result = r_result;
  assign eng_start  = r_start;
  assign eng_a      = r_eng_a;
  assign eng_b      = r_eng_b;
  assign busy       = r_busy;

`ifdef GCD_TIMEOUT_EN
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_gcd_sched
// Brief    : Directed self-checking bench for gcd_sched with a behavioural engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gcd_sched;

  localparam int W    = 5;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_err;
  logic              eng_start;
  logic [W-1:0]      eng_a;
  logic [W-1:0]      eng_b;
  logic              eng_done;
  logic [W-1:0]      eng_result;
  logic              busy;

  int n_chk;
  int n_pass;
  int n_starts;
  int eng_lat;
  bit eng_hang;

  gcd_sched #(.W(W), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] f_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; (i < 64) && (y != 0); i++) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural engine: answers eng_lat cycles after start, or never when hung.
  logic [W-1:0] e_a, e_b;
  int           e_cnt;
  bit           e_busy;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_busy     <= 1'b0;
      e_cnt      <= 0;
      eng_done   <= 1'b0;
      eng_result <= '0;
      e_a        <= '0;
      e_b        <= '0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) begin
        e_busy <= 1'b1;
        e_cnt  <= eng_lat;
        e_a    <= eng_a;
        e_b    <= eng_b;
      end else if (e_busy) begin
        if (e_cnt <= 1) begin
          e_busy <= 1'b0;
          if (!eng_hang) begin
            eng_done   <= 1'b1;
            eng_result <= f_gcd(e_a, e_b);
          end
        end else begin
          e_cnt <= e_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (eng_start) n_starts++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input int a, input int b);
    a_in[id*W +: W] = a[W-1:0];
    b_in[id*W +: W] = b[W-1:0];
  endtask

  task automatic wait_gnt(input int id);
    int n;
    n = 0;
    while ((gnt == '0) && (n < 20)) begin
      tick();
      n++;
    end
    chk("gnt", 32'(gnt), 32'(1 << id));
  endtask

  // One job: grant, optional engine phase, response, handshake when ready.
  task automatic serve(input int id, input int exp_res, input bit zero, input logic [NREQ-1:0] req_after);
    int n;
    logic pd;
    logic [W-1:0] ea, eb;
    ea = a_in[id*W +: W];
    eb = b_in[id*W +: W];
    wait_gnt(id);
    tick();
    req = req_after;
    if (zero) begin
      chk("zero_no_start", 32'(eng_start), 0);
      chk("zero_latency", 32'(rsp_valid), 1);
    end else begin
      chk("eng_start", 32'(eng_start), 1);
      chk("eng_a", 32'(eng_a), 32'(ea));
      chk("eng_b", 32'(eng_b), 32'(eb));
      pd = 1'b0;
      n  = 0;
      while (!rsp_valid && (n < 60)) begin
        pd = eng_done;
        tick();
        n++;
      end
      chk("done_to_valid", 32'(pd), 1);
    end
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_result", 32'(rsp_result), 32'(exp_res));
    chk("rsp_err", 32'(rsp_err), 0);
    if (rsp_ready) begin
      tick();
      chk("rsp_clear", 32'(rsp_valid), 0);
    end
  endtask

  initial begin
    int s0, held, n;
    n_chk    = 0;
    n_pass   = 0;
    n_starts = 0;
    eng_lat  = 4;
    eng_hang = 1'b0;
    reset    = 1'b0;
    req      = '0;
    a_in     = '0;
    b_in     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(rsp_result), 0);
    chk("rst_eng_a", 32'(eng_a), 0);
    reset = 1'b1;
    tick();

    // Rotation from reset pointer: 0,1,2,3 then back to 0.
    eng_lat = 3;
    set_op(0, 12, 18);
    set_op(1, 21, 14);
    set_op(2, 9, 27);
    set_op(3, 17, 5);
    req = 4'b1111;
    serve(0, 6, 1'b0, 4'b1111);
    serve(1, 7, 1'b0, 4'b1111);
    serve(2, 9, 1'b0, 4'b1111);
    serve(3, 1, 1'b0, 4'b1111);
    serve(0, 6, 1'b0, 4'b0000);

    // Zero-operand shortcut never touches the engine.
    s0 = n_starts;
    set_op(2, 0, 10);
    req = 4'b0100;
    serve(2, 10, 1'b1, 4'b0000);
    set_op(2, 0, 0);
    req = 4'b0100;
    serve(2, 0, 1'b1, 4'b0000);
    set_op(1, 7, 0);
    req = 4'b0010;
    serve(1, 7, 1'b1, 4'b0000);
    chk("zero_start_count", 32'(n_starts - s0), 0);

    // Single request through the engine.
    eng_lat = 4;
    set_op(0, 30, 10);
    req = 4'b0001;
    serve(0, 10, 1'b0, 4'b0000);
    chk("idle_busy", 32'(busy), 0);

    // Backpressure: response held, no new grant until the handshake.
    rsp_ready = 1'b0;
    set_op(0, 8, 12);
    req = 4'b0001;
    serve(0, 4, 1'b0, 4'b0000);
    set_op(1, 20, 15);
    req  = 4'b0010;
    held = 0;
    repeat (5) begin
      tick();
      if (rsp_valid && (gnt == '0) && (rsp_result == 5'd4) && (rsp_id == 2'd0)) held++;
    end
    chk("bp_hold", 32'(held), 5);
    chk("bp_busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", 32'(rsp_valid), 0);
    serve(1, 5, 1'b0, 4'b0000);

    // Asynchronous reset while the engine is working.
    eng_lat = 10;
    set_op(0, 15, 25);
    req = 4'b0001;
    wait_gnt(0);
    tick();
    req = 4'b0000;
    tick();
    tick();
    chk("wait_busy", 32'(busy), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_eng_a", 32'(eng_a), 0);
    chk("arst_eng_b", 32'(eng_b), 0);
    chk("arst_result", 32'(rsp_result), 0);
    chk("arst_id", 32'(rsp_id), 0);
    chk("arst_gnt", 32'(gnt), 0);
    set_op(0, 4, 6);
    set_op(1, 10, 4);
    set_op(2, 3, 6);
    set_op(3, 8, 8);
    req     = 4'b1111;
    eng_lat = 3;
    tick();
    chk("arst_hold_valid", 32'(rsp_valid), 0);
    #2;
    reset = 1'b1;
    tick();
    serve(0, 2, 1'b0, 4'b0000);
    chk("arst_no_stale", 32'(rsp_valid), 0);

`ifdef GCD_TIMEOUT_EN
    // Watchdog: engine never answers, error response after 8 WAIT cycles.
    eng_hang = 1'b1;
    set_op(3, 6, 9);
    req = 4'b1000;
    wait_gnt(3);
    tick();
    req = 4'b0000;
    tick();
    n = 0;
    while (!rsp_valid && (n < 40)) begin
      tick();
      n++;
    end
    chk("tmo_latency", 32'(n), 8);
    chk("tmo_err", 32'(rsp_err), 1);
    chk("tmo_result", 32'(rsp_result), 0);
    chk("tmo_id", 32'(rsp_id), 3);
    tick();
    chk("tmo_clear", 32'(rsp_valid), 0);
    eng_hang = 1'b0;
`else
    n = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
- Round-robin scheduler that shares one iterative GCD engine among NREQ requesters.
- Accepts an operand pair from the winning requester and sequences the engine with a start/done handshake.
- Returns the result tagged with the requester ID through a valid/ready response port.
- Sits between the operand sources (switch/load logic, other masters) and the single GCD datapath; handles the zero-operand case without using the engine.

Parameters:
- W, 5, operand/result width in bits
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ
- TIMEOUT, 255, engine watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- a_in  in  NREQ*W  packed operand A; requester i occupies bits [i*W +: W]
- b_in  in  NREQ*W  packed operand B, same packing
- gnt  out  NREQ  one-hot, one-cycle grant pulse; operands captured on this cycle
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  ID of the requester the response belongs to
- rsp_result  out  W  GCD result
- rsp_err  out  1  error flag; stays 0 unless GCD_TIMEOUT_EN is defined
- eng_start  out  1  one-cycle engine start pulse
- eng_a  out  W  engine operand A; held stable from start until done
- eng_b  out  W  engine operand B; held stable from start until done
- eng_done  in  1  engine completion pulse or level; sampled only in WAIT
- eng_result  in  W  engine result, valid while eng_done=1
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state IDLE; last-grant pointer = NREQ-1, so requester 0 has first priority; captured operands cleared.
- FSM states: IDLE, GRANT, ISSUE, WAIT, RESP.
- IDLE: if any req bit is 1, search from (ptr+1) mod NREQ upward with wrap and pick the first set bit as the winner. Go to GRANT.
- GRANT (1 cycle):
  - gnt[winner]=1; capture A and B and the winner ID; update ptr to the winner.
  - If A==0 or B==0, rsp_result = A|B (gcd(0,x)=x, gcd(0,0)=0), then go to RESP; the engine is not started.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): eng_start=1; eng_a/eng_b = captured operands. Go to WAIT.
- WAIT: hold eng_a/eng_b and keep eng_start=0. On eng_done=1, latch eng_result into rsp_result and go to RESP. An eng_done seen in any other state is ignored.
- RESP: rsp_valid=1 with rsp_id/rsp_result/rsp_err stable. When rsp_valid and rsp_ready are both 1, clear rsp_valid the next cycle and return to IDLE. No new grant is issued while a response is pending.
- Latency with a zero operand: gnt to rsp_valid is 1 cycle.
- Latency with an engine job: gnt, then eng_start 1 cycle later; rsp_valid 1 cycle after eng_done.
- Requester rules:
  - Hold req and operands until gnt is seen.
  - req still high on the cycle after gnt counts as a new request.
  - Deasserting req before gnt withdraws the request; no grant is issued for it.
- Simultaneous requests are served in strict rotation: with all NREQ requesting continuously, grants cycle 0,1,2,...,NREQ-1,0,...
- Arbitration happens only in IDLE, so a request arriving during GRANT..RESP waits. There is no starvation under RR.
- Reset mid-operation: the job is dropped and no response is produced. The engine must be reset by the same reset.

Optional Feature:
- Macro: GCD_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT cycles without eng_done, go to RESP with rsp_err=1 and rsp_result=0.
  - A later stray eng_done is ignored.
  - The counter clears on each entry to ISSUE.
- Undefined: no counter exists, rsp_err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Single request: req[0], A=30, B=10; engine model returns 10 after 4 cycles -> gnt=0001, next cycle eng_start=1 with eng_a=30/eng_b=10, then rsp_valid=1, rsp_id=0, rsp_result=10.
- Rotation: req=1111 held for four jobs -> grant order 0,1,2,3; a fifth job -> requester 0; each rsp_id matches its grant.
- Zero shortcut: req[2], A=0, B=10 -> rsp_result=10, rsp_id=2 one cycle after gnt, eng_start never asserted; A=0, B=0 -> rsp_result=0.
- Backpressure: rsp_ready=0 for 5 cycles while req[1] is pending -> response held stable, no gnt until the handshake completes, then gnt[1].
- Async reset during WAIT (A=15, B=25): reset low mid-cycle -> all outputs 0 immediately; after release, req[0] is granted first.
- GCD_TIMEOUT_EN with TIMEOUT=8, engine never done -> rsp_valid 8 cycles after entering WAIT, rsp_err=1, rsp_result=0.
